stereo_frame_scheduler: RTL and testbench

Paces stereo audio output. Once per frame period it pulls one left sample and one right sample from two independent channel producers and serialises them, tagged, into the single 28-bit stream that feeds the bus-side sample FIFO. A missing producer sample is replaced by silence and flagged. A frame tick that cannot be served because the FIFO is back-pressuring is counted and dropped.

---
 rtl/stereo_frame_scheduler_if.sv | 28 ++
 rtl/stereo_frame_scheduler.sv | 152 +++++++++++++++
 tb/tb_stereo_frame_scheduler.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/stereo_frame_scheduler_if.sv
// Handshake bundle between the stereo frame scheduler, its two channel
// producers and the bus-side sample FIFO.
interface stereo_frame_scheduler_if #(
  parameter int SAMPLE_W  = 24,
  parameter int DATA_SIZE = 28
);
  logic                 l_valid;
  logic [SAMPLE_W-1:0]  l_data;
  logic                 l_ready;
  logic                 r_valid;
  logic [SAMPLE_W-1:0]  r_data;
  logic                 r_ready;
  logic                 sink_valid;
  logic [DATA_SIZE-1:0] sink_data;
  logic                 sink_ready;

  // Scheduler side: consumes producer samples, drives the FIFO word.
  modport master (
    input  l_valid, l_data, r_valid, r_data, sink_ready,
    output l_ready, r_ready, sink_valid, sink_data
  );

  // Producer / FIFO side.
  modport slave (
    output l_valid, l_data, r_valid, r_data, sink_ready,
    input  l_ready, r_ready, sink_valid, sink_data
  );
endinterface

// File: rtl/stereo_frame_scheduler.sv
// Stereo frame scheduler: once per TICK_DIV clocks it fetches one left and one
// right sample and emits them as tagged words (bit DATA_SIZE-1 = channel,
// bit DATA_SIZE-2 = underrun). Missing samples become silence and are counted;
// ticks that arrive while a frame is still in flight are counted and dropped.
// DATA_SIZE must be at least SAMPLE_W+2 and TICK_DIV must lie in 8..65535.
module stereo_frame_scheduler #(
  parameter int SAMPLE_W  = 24,
  parameter int DATA_SIZE = 28,
  parameter int TICK_DIV  = 1042,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     clr_stats,
  stereo_frame_scheduler_if.master bus,
  output logic [CNT_W-1:0]         underrun_cnt,
  output logic [CNT_W-1:0]         miss_cnt,
  output logic                     busy
);

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH_L,
    SEND_L,
    FETCH_R,
    SEND_R
  } state_t;

  state_t               state;
  logic [15:0]          div_cnt;
  logic                 tick;
  logic [DATA_SIZE-1:0] l_word;
  logic [DATA_SIZE-1:0] r_word;
  logic                 underrun_inc;
  logic                 miss_inc;

  // Frame pacing: free-running divider while enabled, one-cycle tick on wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (!enable) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == TICK_LAST) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 16'd1;
      tick    <= 1'b0;
    end
  end

  // Build the tagged words; an absent sample is replaced by silence.
  always_comb begin
    l_word = '0;
    l_word[DATA_SIZE-2] = ~bus.l_valid;
    if (bus.l_valid) begin
      l_word[SAMPLE_W-1:0] = bus.l_data;
    end
    r_word = '0;
    r_word[DATA_SIZE-1] = 1'b1;
    r_word[DATA_SIZE-2] = ~bus.r_valid;
    if (bus.r_valid) begin
      r_word[SAMPLE_W-1:0] = bus.r_data;
    end
  end

  // Frame sequencer; every output is registered alongside the state change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      bus.l_ready    <= 1'b0;
      bus.r_ready    <= 1'b0;
      bus.sink_valid <= 1'b0;
      bus.sink_data  <= '0;
      busy           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tick) begin
            state       <= FETCH_L;
            bus.l_ready <= 1'b1;
            busy        <= 1'b1;
          end
        end
        FETCH_L: begin
          state          <= SEND_L;
          bus.l_ready    <= 1'b0;
          bus.sink_valid <= 1'b1;
          bus.sink_data  <= l_word;
        end
        SEND_L: begin
          if (bus.sink_ready) begin
            state          <= FETCH_R;
            bus.sink_valid <= 1'b0;
            bus.r_ready    <= 1'b1;
          end
        end
        FETCH_R: begin
          state          <= SEND_R;
          bus.r_ready    <= 1'b0;
          bus.sink_valid <= 1'b1;
          bus.sink_data  <= r_word;
        end
        SEND_R: begin
          if (bus.sink_ready) begin
            state          <= IDLE;
            bus.sink_valid <= 1'b0;
            busy           <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          bus.l_ready    <= 1'b0;
          bus.r_ready    <= 1'b0;
          bus.sink_valid <= 1'b0;
          busy           <= 1'b0;
        end
      endcase
    end
  end

  // Only one fetch state is active at a time, so one increment per cycle.
  always_comb begin
    underrun_inc = ((state == FETCH_L) && !bus.l_valid) ||
                   ((state == FETCH_R) && !bus.r_valid);
    miss_inc     = tick && (state != IDLE);
  end

  // Saturating statistics; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      underrun_cnt <= '0;
      miss_cnt     <= '0;
    end else if (clr_stats) begin
      underrun_cnt <= '0;
      miss_cnt     <= '0;
    end else begin
      if (underrun_inc && (underrun_cnt != '1)) begin
        underrun_cnt <= underrun_cnt + CNT_W'(1);
      end
      if (miss_inc && (miss_cnt != '1)) begin
        miss_cnt <= miss_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_stereo_frame_scheduler.sv
// Directed bench for stereo_frame_scheduler: a table of per-frame vectors
// followed by hand-written back-pressure, saturation, enable and reset cases.
module tb_stereo_frame_scheduler;

  localparam int SAMPLE_W  = 24;
  localparam int DATA_SIZE = 28;
  localparam int TICK_DIV  = 8;
  localparam int CNT_W     = 4;
  localparam int WAIT_MAX  = 40;

  logic             clk       = 1'b0;
  logic             reset     = 1'b1;
  logic             enable    = 1'b0;
  logic             clr_stats = 1'b0;
  logic [CNT_W-1:0] underrun_cnt;
  logic [CNT_W-1:0] miss_cnt;
  logic             busy;

  int vec_count   = 0;
  int miscompares = 0;

  stereo_frame_scheduler_if #(.SAMPLE_W(SAMPLE_W), .DATA_SIZE(DATA_SIZE)) bus ();

  stereo_frame_scheduler #(
    .SAMPLE_W (SAMPLE_W),
    .DATA_SIZE(DATA_SIZE),
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .clr_stats   (clr_stats),
    .bus         (bus),
    .underrun_cnt(underrun_cnt),
    .miss_cnt    (miss_cnt),
    .busy        (busy)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  typedef struct {
    logic                 l_valid;
    logic [SAMPLE_W-1:0]  l_data;
    logic                 r_valid;
    logic [SAMPLE_W-1:0]  r_data;
    logic [DATA_SIZE-1:0] exp_l;
    logic [DATA_SIZE-1:0] exp_r;
    logic [CNT_W-1:0]     exp_under;
  } vec_t;

  vec_t vecs [6];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic lv, input logic [SAMPLE_W-1:0] ld,
                               input logic rv, input logic [SAMPLE_W-1:0] rd);
    bus.l_valid = lv;
    bus.l_data  = ld;
    bus.r_valid = rv;
    bus.r_data  = rd;
  endtask

  // Called at a negedge; samples every negedge until 'want' words transferred,
  // then steps one more negedge so the last word is not seen twice.
  task automatic captureFrame(input int want, output logic [DATA_SIZE-1:0] w0,
                              output logic [DATA_SIZE-1:0] w1, output int n,
                              output int nl, output int nr);
    n  = 0;
    nl = 0;
    nr = 0;
    w0 = '0;
    w1 = '0;
    for (int k = 0; k < WAIT_MAX; k++) begin
      if (bus.l_ready) nl++;
      if (bus.r_ready) nr++;
      if (bus.sink_valid && bus.sink_ready) begin
        if (n == 0) w0 = bus.sink_data;
        else        w1 = bus.sink_data;
        n++;
      end
      @(negedge clk);
      if (n >= want) break;
    end
  endtask

  // Counts rising clock edges until l_ready is seen high (0 on timeout).
  task automatic waitLReady(output int cycles);
    cycles = 0;
    for (int k = 1; k <= WAIT_MAX; k++) begin
      @(posedge clk);
      #1;
      if (bus.l_ready) begin
        cycles = k;
        break;
      end
    end
  endtask

  task automatic pulseClear();
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
  endtask

  initial begin
    logic [DATA_SIZE-1:0] w0;
    logic [DATA_SIZE-1:0] w1;
    int n, nl, nr, cyc, frames_ok, hits;
    logic stable;

    vecs[0] = '{1'b1, 24'h123456, 1'b1, 24'hABCDEF, 28'h0123456, 28'h8ABCDEF, 4'd0};
    vecs[1] = '{1'b1, 24'h123456, 1'b1, 24'hABCDEF, 28'h0123456, 28'h8ABCDEF, 4'd0};
    vecs[2] = '{1'b0, 24'h5A5A5A, 1'b1, 24'hABCDEF, 28'h4000000, 28'h8ABCDEF, 4'd1};
    vecs[3] = '{1'b1, 24'h000001, 1'b0, 24'hFFFFFF, 28'h0000001, 28'hC000000, 4'd2};
    vecs[4] = '{1'b0, 24'h7FFFFF, 1'b0, 24'h000F00, 28'h4000000, 28'hC000000, 4'd4};
    vecs[5] = '{1'b1, 24'hFFFFFF, 1'b1, 24'h800000, 28'h0FFFFFF, 28'h8800000, 4'd4};

    applyStimulus(1'b1, 24'h123456, 1'b1, 24'hABCDEF);
    bus.sink_ready = 1'b1;
    #2 reset = 1'b0;

    // Reset state
    @(negedge clk);
    checkOutput("rst_sink_valid", 32'(bus.sink_valid), 32'd0);
    checkOutput("rst_sink_data", 32'(bus.sink_data), 32'd0);
    checkOutput("rst_l_ready", 32'(bus.l_ready), 32'd0);
    checkOutput("rst_r_ready", 32'(bus.r_ready), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_underrun", 32'(underrun_cnt), 32'd0);
    checkOutput("rst_miss", 32'(miss_cnt), 32'd0);
    @(negedge clk);
    reset  = 1'b1;
    enable = 1'b1;

    // Table of frames with free-flowing sink
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].l_valid, vecs[i].l_data, vecs[i].r_valid, vecs[i].r_data);
      captureFrame(2, w0, w1, n, nl, nr);
      checkOutput($sformatf("v%0d_nwords", i), n, 32'd2);
      checkOutput($sformatf("v%0d_lword", i), 32'(w0), 32'(vecs[i].exp_l));
      checkOutput($sformatf("v%0d_rword", i), 32'(w1), 32'(vecs[i].exp_r));
      checkOutput($sformatf("v%0d_lready_pulses", i), nl, 32'd1);
      checkOutput($sformatf("v%0d_rready_pulses", i), nr, 32'd1);
      checkOutput($sformatf("v%0d_underrun", i), 32'(underrun_cnt), 32'(vecs[i].exp_under));
      checkOutput($sformatf("v%0d_miss", i), 32'(miss_cnt), 32'd0);
    end

    // Back-pressure: stall SEND_L for 19 cycles. Ticks at +8 and +16 land in
    // the stall; the frame finishes at +23 so the +24 tick is served normally.
    applyStimulus(1'b1, 24'h123456, 1'b1, 24'hABCDEF);
    pulseClear();
    checkOutput("bp_clr_underrun", 32'(underrun_cnt), 32'd0);
    for (int k = 0; k < WAIT_MAX; k++) begin
      if (bus.sink_valid) break;
      @(negedge clk);
    end
    checkOutput("bp_reach_send_l", 32'(bus.sink_valid), 32'd1);
    bus.sink_ready = 1'b0;
    stable = 1'b1;
    repeat (19) begin
      @(negedge clk);
      if (!(bus.sink_valid === 1'b1 && bus.sink_data === 28'h0123456 &&
            bus.l_ready === 1'b0 && bus.r_ready === 1'b0)) stable = 1'b0;
    end
    checkOutput("bp_word_stable", 32'(stable), 32'd1);
    checkOutput("bp_miss", 32'(miss_cnt), 32'd2);
    bus.sink_ready = 1'b1;
    captureFrame(2, w0, w1, n, nl, nr);
    checkOutput("bp_release_lword", 32'(w0), 32'h0123456);
    checkOutput("bp_release_rword", 32'(w1), 32'h8ABCDEF);
    captureFrame(2, w0, w1, n, nl, nr);
    checkOutput("bp_next_lword", 32'(w0), 32'h0123456);
    checkOutput("bp_next_rword", 32'(w1), 32'h8ABCDEF);
    checkOutput("bp_next_lready", nl, 32'd1);
    checkOutput("bp_miss_after", 32'(miss_cnt), 32'd2);

    // Clear coincident with an underrun increment at a non-saturated count
    applyStimulus(1'b0, 24'h111111, 1'b1, 24'hABCDEF);
    pulseClear();
    checkOutput("clr_miss", 32'(miss_cnt), 32'd0);
    captureFrame(2, w0, w1, n, nl, nr);
    checkOutput("clr_pre_underrun", 32'(underrun_cnt), 32'd1);
    for (int k = 0; k < WAIT_MAX; k++) begin
      if (bus.l_ready) break;
      @(negedge clk);
    end
    checkOutput("clr_reach_fetch_l", 32'(bus.l_ready), 32'd1);
    pulseClear();
    checkOutput("clr_coincident", 32'(underrun_cnt), 32'd0);
    captureFrame(2, w0, w1, n, nl, nr);
    checkOutput("clr_lword", 32'(w0), 32'h4000000);
    checkOutput("clr_underrun_after", 32'(underrun_cnt), 32'd0);

    // Saturation: 20 left-underrun frames on a 4-bit counter
    frames_ok = 0;
    repeat (20) begin
      captureFrame(2, w0, w1, n, nl, nr);
      if (n == 2 && w0 == 28'h4000000 && w1 == 28'h8ABCDEF) frames_ok++;
    end
    checkOutput("sat_frames", frames_ok, 32'd20);
    checkOutput("sat_underrun", 32'(underrun_cnt), 32'd15);
    checkOutput("sat_miss", 32'(miss_cnt), 32'd0);

    // Enable dropped during FETCH_R: the frame still completes
    applyStimulus(1'b1, 24'h123456, 1'b1, 24'hABCDEF);
    for (int k = 0; k < WAIT_MAX; k++) begin
      if (bus.r_ready) break;
      @(negedge clk);
    end
    checkOutput("en_reach_fetch_r", 32'(bus.r_ready), 32'd1);
    enable = 1'b0;
    captureFrame(1, w0, w1, n, nl, nr);
    checkOutput("en_rword_count", n, 32'd1);
    checkOutput("en_rword", 32'(w0), 32'h8ABCDEF);
    checkOutput("en_idle", 32'(busy), 32'd0);
    hits = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.l_ready || busy) hits++;
    end
    checkOutput("en_no_ticks", hits, 32'd0);
    enable = 1'b1;
    waitLReady(cyc);
    checkOutput("en_first_lready", cyc, 32'(TICK_DIV + 1));
    waitLReady(cyc);
    checkOutput("en_lready_period", cyc, 32'(TICK_DIV));
    @(negedge clk);
    captureFrame(2, w0, w1, n, nl, nr);

    // Asynchronous reset in SEND_L with one missed tick recorded
    applyStimulus(1'b0, 24'h222222, 1'b1, 24'hABCDEF);
    for (int k = 0; k < WAIT_MAX; k++) begin
      if (bus.sink_valid) break;
      @(negedge clk);
    end
    bus.sink_ready = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("ar_pre_miss", 32'(miss_cnt), 32'd1);
    checkOutput("ar_pre_busy", 32'(busy), 32'd1);
    checkOutput("ar_pre_underrun", 32'(underrun_cnt), 32'd15);
    reset = 1'b0;
    #1;
    checkOutput("ar_sink_valid", 32'(bus.sink_valid), 32'd0);
    checkOutput("ar_sink_data", 32'(bus.sink_data), 32'd0);
    checkOutput("ar_busy", 32'(busy), 32'd0);
    checkOutput("ar_underrun", 32'(underrun_cnt), 32'd0);
    checkOutput("ar_miss", 32'(miss_cnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    applyStimulus(1'b1, 24'h123456, 1'b1, 24'hABCDEF);
    bus.sink_ready = 1'b1;
    reset = 1'b1;
    waitLReady(cyc);
    checkOutput("ar_first_lready", cyc, 32'(TICK_DIV + 1));
    @(negedge clk);
    captureFrame(2, w0, w1, n, nl, nr);
    checkOutput("ar_lword", 32'(w0), 32'h0123456);
    checkOutput("ar_rword", 32'(w1), 32'h8ABCDEF);
    checkOutput("ar_post_underrun", 32'(underrun_cnt), 32'd0);
    checkOutput("ar_post_miss", 32'(miss_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
